// File: rtl/traffic_phase_scheduler.sv
// Highway/country intersection phase controller.
// Tick-timed green/yellow/all-red sequencing with ped and preempt.
module traffic_phase_scheduler #(
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 10,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       car_x,
  input  logic       ped_req,
  input  logic       preempt,
  output logic [2:0] hwy,
  output logic [2:0] cntry,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    HG  = 3'd0,
    HY  = 3'd1,
    AR1 = 3'd2,
    CG  = 3'd3,
    CY  = 3'd4,
    AR2 = 3'd5
  } state_e;

  localparam logic [2:0] L_RED = 3'b001;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b100;

  localparam logic [CNT_W-1:0] T_GMIN = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] T_GMAX = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] T_YEL  = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] T_AR   = CNT_W'(ALLRED_T);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             ped_q, ped_d;
  logic             wact_q, wact_d;
  logic             enter_cg, exit_cg;

  // State, dwell counter and pedestrian flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HG;
      tcnt_q  <= '0;
      ped_q   <= 1'b0;
      wact_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      ped_q   <= ped_d;
      wact_q  <= wact_d;
    end
  end

  // Next-state selection from dwell and demand.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HG: begin
        if (tcnt_q >= T_GMIN && (car_x || ped_q) && !preempt)
          state_d = HY;
      end
      HY: begin
        if (tcnt_q >= T_YEL)
          state_d = AR1;
      end
      AR1: begin
        if (tcnt_q >= T_AR)
          state_d = preempt ? AR2 : CG;
      end
      CG: begin
        if (preempt || tcnt_q >= T_GMAX ||
            (tcnt_q >= T_GMIN && !car_x))
          state_d = CY;
      end
      CY: begin
        if (tcnt_q >= T_YEL)
          state_d = AR2;
      end
      AR2: begin
        if (tcnt_q >= T_AR)
          state_d = HG;
      end
      default: state_d = HG;
    endcase
  end

  // Dwell counter: clears on any state change, saturates.
  always_comb begin
    tcnt_d = tcnt_q;
    if (state_d != state_q)
      tcnt_d = '0;
    else if (tick && tcnt_q != '1)
      tcnt_d = tcnt_q + CNT_W'(1);
  end

  // Pedestrian request latch and walk grant for the country green.
  always_comb begin
    enter_cg = (state_q == AR1) && (state_d == CG);
    exit_cg  = (state_q == CG) && (state_d != CG);
    ped_d    = ped_q | ped_req;
    wact_d   = wact_q;
    if (enter_cg) begin
      wact_d = ped_q | ped_req;
      ped_d  = 1'b0;
    end else if (exit_cg) begin
      wact_d = 1'b0;
    end
  end

  // Moore lamp decode; illegal codes show all-red.
  always_comb begin
    hwy   = L_RED;
    cntry = L_RED;
    case (state_q)
      HG: hwy   = L_GRN;
      HY: hwy   = L_YEL;
      CG: cntry = L_GRN;
      CY: cntry = L_YEL;
      default: ;
    endcase
    walk  = (state_q == CG) && wact_q;
    phase = state_q;
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler.
// Directed scenarios plus random stimulus vs a rule-level model.
module tb_traffic_phase_scheduler;

  localparam int GMIN = 4;
  localparam int GMAX = 10;
  localparam int YT   = 2;
  localparam int ART  = 1;
  localparam int CMAX = 15;

  logic       clk = 1'b0;
  logic       reset, tick, car_x, ped_req, preempt;
  logic [2:0] hwy, cntry, phase;
  logic       walk;

  int n_tests = 0;
  int n_fail  = 0;

  int m_ph, m_cnt;
  bit m_pend, m_wact;

  int hwy_tab[6]   = '{4, 2, 1, 1, 1, 1};
  int cntry_tab[6] = '{1, 1, 1, 4, 2, 1};
  int rec[$];

  traffic_phase_scheduler dut (
    .clk(clk), .reset(reset), .tick(tick), .car_x(car_x),
    .ped_req(ped_req), .preempt(preempt),
    .hwy(hwy), .cntry(cntry), .walk(walk), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_cnt = 0; m_pend = 0; m_wact = 0;
  endtask

  // One clock edge of the intersection rules.
  task automatic model_step(input bit t, input bit c,
                            input bit p, input bit pr);
    int nx;
    nx = m_ph;
    if (m_ph == 0 && m_cnt >= GMIN && (c || m_pend) && !pr) nx = 1;
    if (m_ph == 1 && m_cnt >= YT) nx = 2;
    if (m_ph == 2 && m_cnt >= ART) nx = pr ? 5 : 3;
    if (m_ph == 3 && (pr || m_cnt >= GMAX || (m_cnt >= GMIN && !c)))
      nx = 4;
    if (m_ph == 4 && m_cnt >= YT) nx = 5;
    if (m_ph == 5 && m_cnt >= ART) nx = 0;
    if (m_ph == 2 && nx == 3) begin
      m_wact = m_pend | p;
      m_pend = 0;
    end else begin
      if (p) m_pend = 1;
      if (m_ph == 3 && nx != 3) m_wact = 0;
    end
    if (nx != m_ph) m_cnt = 0;
    else if (t && m_cnt < CMAX) m_cnt++;
    m_ph = nx;
  endtask

  task automatic check_outs();
    chk("phase", phase, m_ph);
    chk("hwy", hwy, hwy_tab[m_ph]);
    chk("cntry", cntry, cntry_tab[m_ph]);
    chk("walk", walk, (m_ph == 3) && m_wact);
  endtask

  task automatic cycle(input bit t, input bit c,
                       input bit p, input bit pr);
    @(negedge clk);
    tick = t; car_x = c; ped_req = p; preempt = pr;
    @(posedge clk);
    model_step(t, c, p, pr);
    #1 check_outs();
  endtask

  // Async reset mid-cycle, checked before the next edge.
  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    tick = 0; car_x = 0; ped_req = 0; preempt = 0;
    model_reset();
    #1 check_outs();
    @(negedge clk);
    reset = 1'b0;
    check_outs();
  endtask

  task automatic run_to(input int ph, input bit c, input string tag);
    int k;
    k = 0;
    while (int'(phase) != ph && k < 40) begin
      cycle(1, c, 0, 0);
      k++;
    end
    chk(tag, int'(phase) == ph, 1);
  endtask

  initial begin
    int exp_runs[6] = '{5, 3, 2, 11, 3, 2};
    int runs[$];
    int cg_n, wk_n, hg_n, len;
    bit rc, rpr, rp;

    reset = 1'b1; tick = 0; car_x = 0; ped_req = 0; preempt = 0;
    model_reset();
    #12 check_outs();
    reset = 1'b0;

    // Idle highway stays green.
    do_reset();
    for (int i = 0; i < 30; i++) cycle(1, 0, 0, 0);

    // Full cycle with a waiting car; country green runs to max.
    do_reset();
    rec.delete();
    rec.push_back(int'(phase));
    for (int i = 0; i < 30; i++) begin
      cycle(1, 1, 0, 0);
      rec.push_back(int'(phase));
    end
    runs.delete();
    len = 1;
    for (int i = 1; i < rec.size(); i++) begin
      if (rec[i] == rec[i-1]) len++;
      else begin runs.push_back(len); len = 1; end
    end
    for (int i = 0; i < 6; i++)
      chk($sformatf("run%0d", i), (i < runs.size()) ? runs[i] : -1,
          exp_runs[i]);

    // Single pedestrian pulse with no car.
    do_reset();
    cg_n = 0; wk_n = 0;
    for (int i = 1; i <= 30; i++) begin
      cycle(1, 0, i == 2, 0);
      if (phase == 3'd3) begin
        cg_n++;
        if (walk) wk_n++;
      end
    end
    chk("ped_cg_len", cg_n, 5);
    chk("ped_walk_len", wk_n, 5);

    // Preempt cuts country green, then holds highway.
    do_reset();
    run_to(3, 1, "reach_cg");
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 1);
    chk("preempt_cy", phase, 3'd4);
    hg_n = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(1, 1, 0, 1);
      if (phase == 3'd0) hg_n++;
    end
    chk("preempt_hold", hg_n >= 20, 1);

    // Sparse ticks freeze dwell between ticks.
    do_reset();
    for (int i = 0; i < 160; i++) cycle(i % 4 == 0, 1, 0, 0);

    // Reset in yellow discards a pending request.
    do_reset();
    run_to(3, 1, "reach_cg2");
    cycle(1, 1, 1, 0);
    run_to(4, 1, "reach_cy");
    do_reset();
    wk_n = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1, 1, 0, 0);
      if (walk) wk_n++;
    end
    chk("no_stale_walk", wk_n, 0);

    // Random traffic.
    for (int b = 0; b < 3; b++) begin
      do_reset();
      rc = 0; rpr = 0;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(7) == 0) rc = ~rc;
        if ($urandom_range(15) == 0) rpr = ~rpr;
        rp = ($urandom_range(11) == 0);
        cycle($urandom_range(3) != 0, rc, rp, rpr);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
